// File: rtl/rlgl_game_ctrl.sv
// Red-Light-Green-Light referee: synchronizes lights and buttons, counts steps, decides WIN/LOSE.
// Optional red-phase limit per game is built when RLGL_TIMEOUT_EN is defined.
module rlgl_game_ctrl #(
   parameter int GOAL_STEPS     = 16,
   parameter int POS_W          = 5,
   parameter int GRACE_CYCLES   = 25_000_000,
   parameter int GRACE_W        = 26,
   parameter int MAX_RED_PHASES = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             red,
   input  logic             green,
   input  logic             move,
   input  logic             start,
   output logic [1:0]       state,
   output logic [POS_W-1:0] position,
   output logic             playing,
   output logic             win,
   output logic             lose,
   output logic             timeout
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_PLAY = 2'b01;
   localparam logic [1:0] ST_WIN  = 2'b10;
   localparam logic [1:0] ST_LOSE = 2'b11;

   localparam int SIG_RED   = 0;
   localparam int SIG_GREEN = 1;
   localparam int SIG_MOVE  = 2;
   localparam int SIG_START = 3;

   if (GOAL_STEPS < 1 || GOAL_STEPS >= 2**POS_W || MAX_RED_PHASES < 1) begin : g_bad_param
      $error("rlgl_game_ctrl: parameter out of range");
   end

   logic [3:0] raw_in;
   logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
   logic       red_rise_q, red_rise_d, step_q, step_d, start_rise_q, start_rise_d;
   logic [1:0]         state_q, state_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [GRACE_W-1:0] grace_q, grace_d;
   logic               is_red, grace;

   assign raw_in = {start, move, green, red};

   // dly_q is the level aligned with the registered edge pulses
   always_comb begin
      sync1_d      = raw_in;
      sync2_d      = sync1_q;
      dly_d        = sync2_q;
      red_rise_d   = sync2_q[SIG_RED]   & ~dly_q[SIG_RED];
      step_d       = sync2_q[SIG_MOVE]  & ~dly_q[SIG_MOVE];
      start_rise_d = sync2_q[SIG_START] & ~dly_q[SIG_START];
   end

   assign is_red = dly_q[SIG_RED] | (dly_q[SIG_RED] == dly_q[SIG_GREEN]);
   assign grace  = red_rise_q | (grace_q != '0);

`ifdef RLGL_TIMEOUT_EN
   localparam int PH_W = $clog2(MAX_RED_PHASES + 1);
   logic [PH_W-1:0] phase_q, phase_d;
   logic            timeout_q, timeout_d;
`endif

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      grace_d = grace_q;
      if (grace_q != '0) grace_d = grace_q - 1'b1;
      if (red_rise_q)    grace_d = GRACE_W'(GRACE_CYCLES);
`ifdef RLGL_TIMEOUT_EN
      phase_d   = phase_q;
      timeout_d = timeout_q;
`endif
      case (state_q)
         ST_PLAY: begin
`ifdef RLGL_TIMEOUT_EN
            if (red_rise_q) begin
               phase_d = phase_q + 1'b1;
               if (phase_d >= PH_W'(MAX_RED_PHASES)) begin
                  state_d   = ST_LOSE;
                  timeout_d = 1'b1;
               end
            end
`endif
            // step outcomes override a simultaneous phase-limit loss
            if (step_q) begin
               if (grace || !is_red) begin
                  pos_d = pos_q + 1'b1;
                  if (pos_d == POS_W'(GOAL_STEPS)) begin
                     state_d = ST_WIN;
`ifdef RLGL_TIMEOUT_EN
                     timeout_d = 1'b0;
`endif
                  end
               end else begin
                  state_d = ST_LOSE;
`ifdef RLGL_TIMEOUT_EN
                  timeout_d = 1'b0;
`endif
               end
            end
         end
         default: begin
            if (start_rise_q) begin
               state_d = ST_PLAY;
               pos_d   = '0;
               grace_d = '0;
`ifdef RLGL_TIMEOUT_EN
               phase_d   = '0;
               timeout_d = 1'b0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         dly_q        <= '0;
         red_rise_q   <= 1'b0;
         step_q       <= 1'b0;
         start_rise_q <= 1'b0;
         state_q      <= ST_IDLE;
         pos_q        <= '0;
         grace_q      <= '0;
`ifdef RLGL_TIMEOUT_EN
         phase_q      <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         dly_q        <= dly_d;
         red_rise_q   <= red_rise_d;
         step_q       <= step_d;
         start_rise_q <= start_rise_d;
         state_q      <= state_d;
         pos_q        <= pos_d;
         grace_q      <= grace_d;
`ifdef RLGL_TIMEOUT_EN
         phase_q      <= phase_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   assign state    = state_q;
   assign position = pos_q;
   assign playing  = (state_q == ST_PLAY);
   assign win      = (state_q == ST_WIN);
   assign lose     = (state_q == ST_LOSE);
`ifdef RLGL_TIMEOUT_EN
   assign timeout  = timeout_q;
`else
   assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rlgl_game_ctrl.sv
// Directed bench for rlgl_game_ctrl with GOAL_STEPS=4, GRACE_CYCLES=4, MAX_RED_PHASES=2.
module tb_rlgl_game_ctrl;

   localparam int POS_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             red = 1'b0;
   logic             green = 1'b1;
   logic             move = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       state;
   logic [POS_W-1:0] position;
   logic             playing, win, lose, timeout;

   int vectors = 0;
   int miscompares = 0;

   rlgl_game_ctrl #(
      .GOAL_STEPS(4), .POS_W(POS_W), .GRACE_CYCLES(4), .GRACE_W(4), .MAX_RED_PHASES(2)
   ) dut (
      .clk(clk), .rst(rst), .red(red), .green(green), .move(move), .start(start),
      .state(state), .position(position), .playing(playing), .win(win),
      .lose(lose), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
      $display("vec %0d %s: observed %0h expected %0h", vectors, tag, got, exp);
   endtask

   task automatic pulse_move();
      move = 1'b1; tick(2); move = 1'b0; tick(3);
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(2); start = 1'b0; tick(3);
   endtask

   task automatic chk_game(input string tag, input logic [1:0] st, input int pos);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".position"}, 32'(position), 32'(pos));
   endtask

   initial begin
      // 1: reset with inputs toggling
      tick(1);
      move = 1'b1; start = 1'b0; tick(1);
      move = 1'b0; start = 1'b1; tick(1);
      chk_game("rst", 2'b00, 0);
      chk("rst.playing", 32'(playing), 32'd0);
      chk("rst.win", 32'(win), 32'd0);
      chk("rst.lose", 32'(lose), 32'd0);
      chk("rst.timeout", 32'(timeout), 32'd0);
      start = 1'b0; rst = 1'b0; tick(4);
      chk("idle_hold.state", 32'(state), 32'd0);

      // 2: start, then three steps on green
      pulse_start();
      chk_game("start", 2'b01, 0);
      pulse_move(); chk("step1.position", 32'(position), 32'd1);
      pulse_move(); chk("step2.position", 32'(position), 32'd2);
      pulse_move(); chk("step3.position", 32'(position), 32'd3);
      chk("step3.playing", 32'(playing), 32'd1);
      pulse_start();
      chk_game("start_in_play", 2'b01, 3);

      // 4: goal reached, extra step ignored, restart
      pulse_move();
      chk_game("win", 2'b10, 4);
      chk("win.win", 32'(win), 32'd1);
      pulse_move();
      chk_game("win_hold", 2'b10, 4);
      pulse_start();
      chk_game("restart", 2'b01, 0);
      pulse_move();
      chk("pos1.position", 32'(position), 32'd1);

      // 3a: step two cycles after red rises is inside grace
      red = 1'b1; green = 1'b0; tick(2);
      pulse_move();
      chk_game("grace_step", 2'b01, 2);
      // 3b: step ten cycles after red rises loses
      tick(3);
      pulse_move();
      chk_game("red_step", 2'b11, 2);
      chk("red_step.lose", 32'(lose), 32'd1);
      chk("red_step.playing", 32'(playing), 32'd0);
      chk("red_step.timeout", 32'(timeout), 32'd0);

      // invalid light pair counts as red
      red = 1'b0; green = 1'b0; tick(4);
      pulse_start();
      chk_game("inv_start", 2'b01, 0);
      pulse_move();
      chk_game("inv_step", 2'b11, 0);

      // 5: reset mid-game, then moves without start
      red = 1'b0; green = 1'b1; tick(4);
      pulse_start();
      pulse_move(); pulse_move();
      chk_game("mid_game", 2'b01, 2);
      rst = 1'b1; tick(1);
      chk_game("mid_rst", 2'b00, 0);
      chk("mid_rst.playing", 32'(playing), 32'd0);
      rst = 1'b0;
      pulse_move(); pulse_move();
      chk_game("no_start", 2'b00, 0);

      // 6: two red phases without moving
      pulse_start();
      chk_game("ph_start", 2'b01, 0);
      red = 1'b1; green = 1'b0; tick(3);
      red = 1'b0; green = 1'b1; tick(3);
      red = 1'b1; green = 1'b0; tick(6);
`ifdef RLGL_TIMEOUT_EN
      chk("phases.state", 32'(state), 32'd3);
      chk("phases.timeout", 32'(timeout), 32'd1);
      chk("phases.lose", 32'(lose), 32'd1);
`else
      chk("phases.state", 32'(state), 32'd1);
      chk("phases.timeout", 32'(timeout), 32'd0);
      chk("phases.lose", 32'(lose), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
